imem_rr_arbiter: RTL
====================

Name: imem_rr_arbiter

Overview:
- Round-robin arbiter that shares one single-port on-chip instruction memory among NUM_MASTERS Avalon-MM masters (Nios II instruction masters plus a loader/debug master).
- Memory geometry: 16384 x 32 bit, byte-enabled, one-cycle read latency.
- Sits between the masters and the memory slave in the MPSoC system.
- Issues at most one access per cycle and pipelines reads so that back-to-back grants sustain one word per clock.

Parameters:
NUM_MASTERS, 4, number of requesting masters (2..8)
ADDR_W, 14, word address width
DATA_W, 32, data width
BE_W, 4, byte-enable width (DATA_W/8)

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
m_address  in  NUM_MASTERS*ADDR_W  per-master word address, master i at [i*ADDR_W +: ADDR_W]
m_read  in  NUM_MASTERS  per-master read request
m_write  in  NUM_MASTERS  per-master write request
m_writedata  in  NUM_MASTERS*DATA_W  per-master write data
m_byteenable  in  NUM_MASTERS*BE_W  per-master byte enables
m_waitrequest  out  NUM_MASTERS  stall, per master
m_readdata  out  DATA_W  shared registered read data
m_readdatavalid  out  NUM_MASTERS  one-hot read-data valid
mem_address  out  ADDR_W  to memory
mem_byteenable  out  BE_W  to memory
mem_chipselect  out  1  to memory
mem_write  out  1  to memory
mem_writedata  out  DATA_W  to memory
mem_clken  out  1  memory clock enable
mem_readdata  in  DATA_W  memory q, valid one cycle after address

Behaviour:
- Reset (reset_n low, async): rr pointer = NUM_MASTERS-1, so master 0 has highest priority first. Pipeline valid/owner regs cleared. m_readdatavalid=0, m_readdata=0.
- Reset is asserted asynchronously and released synchronously to clk.
- req[i] = m_read[i] | m_write[i].
- Grant selection, combinational: first requesting master after the pointer, searching upward and wrapping modulo NUM_MASTERS. At most one grant bit set.
- Pointer updates to the granted index on every cycle with a grant. It holds when there is no request.
- m_waitrequest[i] = req[i] & ~grant[i], combinational. A granted master completes its command in that cycle.
- Memory drive:
  - mem_chipselect = |grant.
  - mem_address, mem_byteenable and mem_writedata are muxed from the granted master.
  - mem_write = m_write of the granted master.
  - With no grant, address/data are don't-care and chipselect = 0.
  - mem_clken = 1 whenever reset_n = 1; 0 during reset.
- Simultaneous m_read and m_write from one master: the write is performed and the read is ignored; no readdatavalid is produced.
- Read pipeline: read granted in cycle T.
  - Stage-1 reg records {valid, owner} at T+1, when mem_readdata is valid.
  - At the T+1 edge, m_readdata <= mem_readdata and m_readdatavalid <= onehot(owner). Both are visible in cycle T+2.
  - Fixed read latency of 2 cycles, no backpressure on read data.
  - Back-to-back reads yield consecutive readdatavalid pulses in grant order.
- Writes produce no readdatavalid.
- m_readdatavalid is a one-cycle pulse; m_readdata holds its last value otherwise.
- Fairness: with all masters requesting continuously, the grant order is 0,1,2,...,N-1,0,... Any waiting master is granted within NUM_MASTERS cycles.
- A single requester is granted every cycle, giving 100% throughput.
- A request deasserted while waiting is simply dropped; there is no lock.
- Reset mid-operation: in-flight reads are discarded and no readdatavalid is emitted afterwards for them.

Optional Feature:
- Macro: IMEM_ARB_WRITE_PROTECT_EN.
- Defined:
  - Only master NUM_MASTERS-1 (loader) may write.
  - A write from any other master is still granted and completes (waitrequest drops) but mem_write is forced to 0 and chipselect to 0.
  - Sticky output wr_violation (1 bit, reset 0) is added, set on such a grant.
  - Per-master sticky vector wr_violation_src[NUM_MASTERS] is added.
- Not defined: all masters may write; no extra ports.

Test Plan:
- Reset, then master 0 reads addr 0x0010 (mem preloaded 0xDEADBEEF) -> waitrequest[0]=0 same cycle; readdatavalid=4'b0001 and m_readdata=0xDEADBEEF two cycles later.
- All 4 masters assert read continuously for 8 cycles -> grants 0,1,2,3,0,1,2,3; each readdatavalid pulses twice, 2 cycles after its grant; non-granted waitrequest=1.
- Master 2 writes 0x12345678 to 0x3FFF with byteenable 4'b0011, then reads it back -> mem_write=1 for one cycle; readback returns 0xXXXX5678 with upper bytes unchanged.
- Master 1 reads at 0x0100..0x0103 alone, back-to-back -> 4 consecutive readdatavalid[1] pulses, one grant per cycle.
- reset_n dropped one cycle after a read grant -> readdatavalid stays 0; pointer resets so master 0 wins the next contention against master 3.
- With IMEM_ARB_WRITE_PROTECT_EN, master 0 writes 0xFFFFFFFF to 0x0010 -> memory unchanged (reads 0xDEADBEEF); wr_violation=1 and wr_violation_src=4'b0001. Master 3 write succeeds.

Source files
------------

// File: rtl/imem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port instruction memory among Avalon-MM masters.
// Define IMEM_ARB_WRITE_PROTECT_EN to restrict writes to the loader master (NUM_MASTERS-1).
module imem_rr_arbiter #(
  parameter int unsigned NUM_MASTERS = 4,
  parameter int unsigned ADDR_W      = 14,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned BE_W        = 4
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [NUM_MASTERS*ADDR_W-1:0] m_address,
  input  logic [NUM_MASTERS-1:0]        m_read,
  input  logic [NUM_MASTERS-1:0]        m_write,
  input  logic [NUM_MASTERS*DATA_W-1:0] m_writedata,
  input  logic [NUM_MASTERS*BE_W-1:0]   m_byteenable,
  output logic [NUM_MASTERS-1:0]        m_waitrequest,
  output logic [DATA_W-1:0]             m_readdata,
  output logic [NUM_MASTERS-1:0]        m_readdatavalid,
  output logic [ADDR_W-1:0]             mem_address,
  output logic [BE_W-1:0]               mem_byteenable,
  output logic                          mem_chipselect,
  output logic                          mem_write,
  output logic [DATA_W-1:0]             mem_writedata,
  output logic                          mem_clken,
`ifdef IMEM_ARB_WRITE_PROTECT_EN
  output logic                          wr_violation,
  output logic [NUM_MASTERS-1:0]        wr_violation_src,
`endif
  input  logic [DATA_W-1:0]             mem_readdata
);

  localparam int unsigned PTR_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

  logic [PTR_W-1:0]       ptr_q, ptr_d;
  logic [PTR_W-1:0]       gidx_c;
  logic [PTR_W-1:0]       idx_c;
  logic [NUM_MASTERS-1:0] req_c, grant_c;
  logic                   gnt_any_c, gnt_wr_c, gnt_rd_c, prot_c;

  logic                   rd_vld_q;
  logic [PTR_W-1:0]       rd_own_q;
  logic [DATA_W-1:0]      rdata_q;
  logic [NUM_MASTERS-1:0] rvalid_q, rvalid_d;

  assign req_c = m_read | m_write;

  // First requester after the pointer, wrapping modulo NUM_MASTERS.
  always_comb begin
    grant_c   = '0;
    gidx_c    = '0;
    idx_c     = '0;
    gnt_any_c = 1'b0;
    for (int unsigned off = 1; off <= NUM_MASTERS; off++) begin
      idx_c = PTR_W'((32'(ptr_q) + off) % NUM_MASTERS);
      if (!gnt_any_c && req_c[idx_c]) begin
        grant_c[idx_c] = 1'b1;
        gidx_c         = idx_c;
        gnt_any_c      = 1'b1;
      end
    end
  end

  assign gnt_wr_c = gnt_any_c & m_write[gidx_c];
  // A combined read+write performs only the write.
  assign gnt_rd_c = gnt_any_c & m_read[gidx_c] & ~m_write[gidx_c];

`ifdef IMEM_ARB_WRITE_PROTECT_EN
  assign prot_c = gnt_wr_c & (gidx_c != PTR_W'(NUM_MASTERS - 1));
`else
  assign prot_c = 1'b0;
`endif

  assign ptr_d         = gnt_any_c ? gidx_c : ptr_q;
  assign m_waitrequest = req_c & ~grant_c;

  assign mem_address    = m_address[32'(gidx_c) * ADDR_W +: ADDR_W];
  assign mem_byteenable = m_byteenable[32'(gidx_c) * BE_W +: BE_W];
  assign mem_writedata  = m_writedata[32'(gidx_c) * DATA_W +: DATA_W];
  assign mem_chipselect = gnt_any_c & ~prot_c;
  assign mem_write      = gnt_wr_c & ~prot_c;
  assign mem_clken      = reset_n;

  always_comb begin
    rvalid_d = '0;
    if (rd_vld_q) rvalid_d[rd_own_q] = 1'b1;
  end

  // Pointer and two-stage read return pipeline.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr_q    <= PTR_W'(NUM_MASTERS - 1);
      rd_vld_q <= 1'b0;
      rd_own_q <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
    end else begin
      ptr_q    <= ptr_d;
      rd_vld_q <= gnt_rd_c;
      rd_own_q <= gidx_c;
      rvalid_q <= rvalid_d;
      if (rd_vld_q) rdata_q <= mem_readdata;
    end
  end

  assign m_readdata      = rdata_q;
  assign m_readdatavalid = rvalid_q;

`ifdef IMEM_ARB_WRITE_PROTECT_EN
  logic                   viol_q;
  logic [NUM_MASTERS-1:0] viol_src_q;

  // Sticky record of blocked writes.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      viol_q     <= 1'b0;
      viol_src_q <= '0;
    end else if (prot_c) begin
      viol_q     <= 1'b1;
      viol_src_q <= viol_src_q | grant_c;
    end
  end

  assign wr_violation     = viol_q;
  assign wr_violation_src = viol_src_q;
`endif

endmodule
